// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel main-memory arbiter. Grants one requesting channel
// at a time, routes its address/store data/write enable to memory and returns
// mem_ready only to that channel. Fixed-priority or round-robin selection, with
// a per-channel lock to keep the grant across the words of a line fill.
module mem_arbiter_n #(
    parameter int NCH = 2,   // requesting channels (2..8)
    parameter int AW  = 32,  // address width
    parameter int DW  = 32,  // store data width
    parameter int RR  = 0    // 0: fixed priority (ch0 highest), 1: round-robin
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH-1:0]    wr_i,
    input  logic [NCH-1:0]    lock_i,
    input  logic [NCH*AW-1:0] addr_i,
    input  logic [NCH*DW-1:0] wdata_i,
    output logic [NCH-1:0]    ready_o,
    output logic [NCH-1:0]    gnt_o,
    output logic [AW-1:0]     mem_a_o,
    output logic [DW-1:0]     mem_st_data_o,
    output logic              mem_access_o,
    output logic              mem_write_o,
    input  logic              mem_ready_i,
    output logic              busy_o
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q;
    logic [NCH-1:0] gnt_q;
    logic [CW-1:0]  ptr_q;   // last released channel; RR scan starts above it

    logic [NCH-1:0] gnt_d;   // one-hot winner if a grant is taken this cycle
    logic [CW-1:0]  win_idx;
    logic [CW-1:0]  gidx;
    logic           sel_req, sel_lock, sel_wr;
    logic           rel_d;   // granted channel gives up the grant this cycle

    // Pick the winner among current requesters
    always_comb begin
        int idx;
        win_idx = '0;
        idx     = 0;
        if (RR != 0) begin
            // Descending scan so the closest channel above ptr is assigned last
            for (int k = NCH; k >= 1; k--) begin
                idx = (int'(ptr_q) + k) % NCH;
                if (req_i[idx[CW-1:0]]) win_idx = idx[CW-1:0];
            end
        end else begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (req_i[c]) win_idx = CW'(c);
            end
        end
        gnt_d          = '0;
        gnt_d[win_idx] = 1'b1;
    end

    // Select the granted channel's controls and its index (for the RR pointer)
    always_comb begin
        gidx     = '0;
        sel_req  = |(gnt_q & req_i);
        sel_lock = |(gnt_q & lock_i);
        sel_wr   = |(gnt_q & wr_i);
        for (int c = 0; c < NCH; c++) begin
            if (gnt_q[c]) gidx = CW'(c);
        end
        // Release on a word without lock, or when the request is abandoned
        // before memory answers
        rel_d = (mem_ready_i && !sel_lock) || (!mem_ready_i && !sel_req);
    end

    // Arbitration FSM: grant on a request in IDLE, release on done/abort
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= CW'(NCH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q <= BUSY;
                        gnt_q   <= gnt_d;
                    end
                end
                BUSY: begin
                    if (rel_d) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= gidx;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Route the granted channel onto the memory bus; all zero while idle
    always_comb begin
        mem_a_o       = '0;
        mem_st_data_o = '0;
        mem_access_o  = 1'b0;
        mem_write_o   = 1'b0;
        if (state_q == BUSY) begin
            for (int c = 0; c < NCH; c++) begin
                if (gnt_q[c]) begin
                    mem_a_o       = addr_i[c*AW +: AW];
                    mem_st_data_o = wdata_i[c*DW +: DW];
                end
            end
            mem_access_o = sel_req;
            mem_write_o  = sel_wr & sel_req;
        end
    end

    // Per-channel ready: only the granted channel sees mem_ready, never in reset
    for (genvar c = 0; c < NCH; c++) begin : g_rdy
        assign ready_o[c] = (state_q == BUSY) & gnt_q[c] & mem_ready_i & ~clr_i;
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a directed preamble on a 2-channel fixed-priority
// instance, then randomized traffic on that and a 4-channel round-robin
// instance, checked by a per-instance scoreboard of completed words.
module tb_mem_arbiter_n;
    typedef struct {
        int          ch;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
    } word_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic [3:0]   req  [2];
    logic [3:0]   wr   [2];
    logic [3:0]   lock [2];
    logic [127:0] addr [2];
    logic [127:0] wdata[2];
    logic         mrdy [2];

    logic [1:0]  rdy0, gnt0;
    logic [3:0]  rdy1, gnt1;
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic        acc[2];
    logic        mw [2];
    logic        bsy[2];
    logic [3:0]  rdy[2];
    logic [3:0]  gnt[2];

    assign rdy[0] = {2'b00, rdy0};
    assign rdy[1] = rdy1;
    assign gnt[0] = {2'b00, gnt0};
    assign gnt[1] = gnt1;

    mem_arbiter_n #(.NCH(2), .AW(32), .DW(32), .RR(0)) dut0 (
        .clk_i(clk), .clr_i(clr), .req_i(req[0][1:0]), .wr_i(wr[0][1:0]),
        .lock_i(lock[0][1:0]), .addr_i(addr[0][63:0]), .wdata_i(wdata[0][63:0]),
        .ready_o(rdy0), .gnt_o(gnt0), .mem_a_o(ma[0]), .mem_st_data_o(md[0]),
        .mem_access_o(acc[0]), .mem_write_o(mw[0]), .mem_ready_i(mrdy[0]),
        .busy_o(bsy[0]));

    mem_arbiter_n #(.NCH(4), .AW(32), .DW(32), .RR(1)) dut1 (
        .clk_i(clk), .clr_i(clr), .req_i(req[1]), .wr_i(wr[1]),
        .lock_i(lock[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .ready_o(rdy1), .gnt_o(gnt1), .mem_a_o(ma[1]), .mem_st_data_o(md[1]),
        .mem_access_o(acc[1]), .mem_write_o(mw[1]), .mem_ready_i(mrdy[1]),
        .busy_o(bsy[1]));

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-channel jobs of 1..4 words; the arbiter serves one
    // job at a time, leaves one idle cycle after a release, and picks the
    // requester nearest above the last served channel (RR) or the lowest one.
    bit          m_busy[2];
    int          m_g   [2];
    int          m_ptr [2];
    bit          pend  [2][4];
    int          words [2][4];
    int          done  [2][4];
    logic [31:0] base  [2][4];
    logic [31:0] dat   [2][4];
    logic        jwr   [2][4];
    word_t       sb0[$];
    word_t       sb1[$];

    function automatic int nch(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int pick(input int i);
        int n    = nch(i);
        int best = -1;
        int bd   = n;
        for (int c = 0; c < n; c++) begin
            if (pend[i][c]) begin
                int d;
                d = (i == 1) ? (c - m_ptr[i] - 1 + 2 * n) % n : c;
                if (d < bd) begin
                    bd   = d;
                    best = c;
                end
            end
        end
        return best;
    endfunction

    task automatic sb_push(input int i, input word_t w);
        if (i == 0) sb0.push_back(w);
        else        sb1.push_back(w);
    endtask

    task automatic sb_pop(input int i, output word_t w, output bit ok);
        ok = 0;
        w  = '{ch: 0, a: '0, d: '0, w: 1'b0};
        if (i == 0) begin
            if (sb0.size() > 0) begin w = sb0.pop_front(); ok = 1; end
        end else begin
            if (sb1.size() > 0) begin w = sb1.pop_front(); ok = 1; end
        end
    endtask

    // One cycle of stimulus for instance i, plus the model's expectation
    task automatic drive_cycle(input int i, input bit gen);
        int n  = nch(i);
        int g  = m_g[i];
        bit mr = 0;
        bit ab = 0;
        word_t w;
        if (gen) begin
            for (int c = 0; c < n; c++) begin
                if (!pend[i][c] && $urandom_range(0, 5) == 0) begin
                    pend[i][c]  = 1;
                    words[i][c] = $urandom_range(1, 4);
                    done[i][c]  = 0;
                    base[i][c]  = $urandom & 32'hFFFF_FFF0;
                    dat[i][c]   = $urandom;
                    jwr[i][c]   = 1'($urandom_range(0, 1));
                end
            end
        end
        if (m_busy[i]) begin
            mr = ($urandom_range(0, 2) == 0);
            ab = !mr && ($urandom_range(0, 15) == 0);
        end
        for (int c = 0; c < 4; c++) begin
            if (c < n) begin
                req[i][c]  = pend[i][c] && !(ab && c == g);
                wr[i][c]   = jwr[i][c];
                lock[i][c] = pend[i][c] && (words[i][c] - done[i][c] > 1);
                addr[i][c*32 +: 32]  = base[i][c] + 32'(4 * done[i][c]);
                wdata[i][c*32 +: 32] = dat[i][c] + 32'(done[i][c]);
            end else begin
                req[i][c]  = 1'b0;
                wr[i][c]   = 1'b0;
                lock[i][c] = 1'b0;
            end
        end
        mrdy[i] = mr;
        if (m_busy[i]) begin
            if (mr) begin
                w.ch = g;
                w.a  = base[i][g] + 32'(4 * done[i][g]);
                w.d  = dat[i][g] + 32'(done[i][g]);
                w.w  = jwr[i][g];
                sb_push(i, w);
                done[i][g]++;
                if (done[i][g] == words[i][g]) begin
                    pend[i][g] = 0;
                    m_busy[i]  = 0;
                    m_ptr[i]   = g;
                end
            end else if (ab) begin
                pend[i][g] = 0;
                m_busy[i]  = 0;
                m_ptr[i]   = g;
            end
        end else begin
            int wn;
            wn = pick(i);
            if (wn >= 0) begin
                m_busy[i] = 1;
                m_g[i]    = wn;
            end
        end
    endtask

    // Monitor: every ready must match the next expected word in order
    bit prev_rel[2] = '{0, 0};
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                word_t e;
                bit    ok;
                chk($sformatf("gnt_onehot%0d", i), 64'($countones(gnt[i]) <= 1), 64'd1);
                if (mrdy[i])
                    chk($sformatf("mem_ready_without_gnt%0d", i), 64'(gnt[i] != 0), 64'd1);
                if (prev_rel[i])
                    chk($sformatf("idle_gap_busy%0d", i), 64'(bsy[i]), 64'd0);
                if (rdy[i] != 0) begin
                    sb_pop(i, e, ok);
                    if (!ok) begin
                        chk($sformatf("unexpected_ready%0d", i), 64'(rdy[i]), 64'd0);
                    end else begin
                        chk($sformatf("ready_ch%0d", i), 64'(rdy[i]), 64'd1 << e.ch);
                        chk($sformatf("mem_a%0d", i), 64'(ma[i]), 64'(e.a));
                        chk($sformatf("mem_st_data%0d", i), 64'(md[i]), 64'(e.d));
                        chk($sformatf("mem_write%0d", i), 64'(mw[i]), 64'(e.w));
                        chk($sformatf("mem_access%0d", i), 64'(acc[i]), 64'd1);
                    end
                end
                prev_rel[i] = (rdy[i] != 0) && ((rdy[i] & lock[i]) == 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int left;
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; wr[i] = '0; lock[i] = '0;
            addr[i] = '0; wdata[i] = '0; mrdy[i] = 1'b0;
            m_busy[i] = 0; m_g[i] = 0; m_ptr[i] = nch(i) - 1;
            for (int c = 0; c < 4; c++) begin
                pend[i][c] = 0; words[i][c] = 0; done[i][c] = 0;
                base[i][c] = '0; dat[i][c] = '0; jwr[i][c] = 1'b0;
            end
        end
        // Directed: two requesters held through reset on the fixed-priority unit
        req[0]            = 4'b0011;
        wr[0]             = 4'b0010;
        addr[0][31:0]     = 32'h100;
        addr[0][63:32]    = 32'h200;
        wdata[0][31:0]    = 32'h1111_2222;
        wdata[0][63:32]   = 32'hDEAD_BEEF;
        repeat (2) begin
            step();
            @(negedge clk);
            chk("reset_gnt", 64'(gnt[0]), 64'd0);
            chk("reset_access", 64'(acc[0]), 64'd0);
            chk("reset_ready", 64'(rdy[0]), 64'd0);
        end
        step(); clr = 1'b0;
        @(negedge clk);
        chk("first_idle_gnt", 64'(gnt[0]), 64'd0);
        step();
        @(negedge clk);
        chk("fixed_gnt_ch0", 64'(gnt[0]), 64'd1);
        chk("fixed_mem_a_ch0", 64'(ma[0]), 64'h100);
        chk("read_mem_write", 64'(mw[0]), 64'd0);
        chk("ch0_access", 64'(acc[0]), 64'd1);
        chk("ch0_busy", 64'(bsy[0]), 64'd1);
        step(); mrdy[0] = 1'b1;
        @(negedge clk);
        chk("ch0_ready", 64'(rdy[0]), 64'd1);
        step(); mrdy[0] = 1'b0; req[0] = 4'b0010;
        @(negedge clk);
        chk("gap_busy", 64'(bsy[0]), 64'd0);
        chk("gap_gnt", 64'(gnt[0]), 64'd0);
        chk("gap_access", 64'(acc[0]), 64'd0);
        step();
        @(negedge clk);
        chk("fixed_gnt_ch1", 64'(gnt[0]), 64'd2);
        chk("fixed_mem_a_ch1", 64'(ma[0]), 64'h200);
        chk("write_mem_write", 64'(mw[0]), 64'd1);
        chk("write_st_data", 64'(md[0]), 64'hDEAD_BEEF);
        step(); clr = 1'b1; mrdy[0] = 1'b1;
        @(negedge clk);
        chk("ready_gated_by_clr", 64'(rdy[0]), 64'd0);
        step(); clr = 1'b0; mrdy[0] = 1'b0; req[0] = '0; wr[0] = '0;
        @(negedge clk);
        chk("after_clr_gnt", 64'(gnt[0]), 64'd0);
        chk("after_clr_busy", 64'(bsy[0]), 64'd0);

        // Randomized traffic on both instances
        mon_en = 1;
        repeat (2500) begin
            step();
            drive_cycle(0, 1);
            drive_cycle(1, 1);
        end
        t = 0;
        left = 1;
        while (left != 0 && t < 500) begin
            step();
            drive_cycle(0, 0);
            drive_cycle(1, 0);
            left = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) left++;
                for (int c = 0; c < 4; c++) if (pend[i][c]) left++;
            end
            t++;
        end
        chk("drain_model_idle", 64'(left), 64'd0);
        repeat (3) begin
            step();
            drive_cycle(0, 0);
            drive_cycle(1, 0);
        end
        @(negedge clk);
        chk("sb0_empty", 64'(sb0.size()), 64'd0);
        chk("sb1_empty", 64'(sb1.size()), 64'd0);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
